// File: rtl/call_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : call_stack_ctrl
// Brief    : Parametrised return-address stack for the MCU core. Holds CALL
//            return addresses in a circular array and presents the RETURN
//            target combinationally. Provides occupancy status, sticky
//            overflow/underflow flags, a selectable push-when-full policy and
//            push+pop tail-call replacement.
//            Optional macro CALL_STACK_DBG_EN adds a read-only debug port
//            (dbg_idx/dbg_data) that peeks at any entry below top.
// Revision : 1.0 - initial release
// ============================================================================
module call_stack_ctrl #(
    parameter int ADDR_W   = 11,
    parameter int DEPTH    = 16,
    parameter int OVF_MODE = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [ADDR_W-1:0]            push_data,
    input  logic                         clr_flags,
`ifdef CALL_STACK_DBG_EN
    input  logic [$clog2(DEPTH)-1:0]     dbg_idx,
    output logic [ADDR_W-1:0]            dbg_data,
`endif
    output logic [ADDR_W-1:0]            top_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] C_LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] C_DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_ONE_CNT   = CNT_W'(1);

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wp;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;
    logic              r_unf;

    logic              w_empty;
    logic              w_full;
    logic [PTR_W-1:0]  w_top_ptr;
    logic [PTR_W-1:0]  w_inc_ptr;
    logic              w_wr_en;
    logic [PTR_W-1:0]  w_wr_ptr;
    logic [PTR_W-1:0]  w_wp_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_ovf_set;
    logic              w_unf_set;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == C_DEPTH_CNT);
    // Pointer wrap is explicit so DEPTH need not be a power of two
    assign w_top_ptr = (r_wp == '0) ? C_LAST_PTR : (r_wp - PTR_W'(1));
    assign w_inc_ptr = (r_wp == C_LAST_PTR) ? '0 : (r_wp + PTR_W'(1));

    // Decode the push/pop request into write, pointer, count and flag effects
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_ptr  = r_wp;
        w_wp_nxt  = r_wp;
        w_cnt_nxt = r_count;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        case ({push, pop})
            2'b11: begin
                if (!w_empty) begin
                    // Tail call: overwrite the current top in place
                    w_wr_en  = 1'b1;
                    w_wr_ptr = w_top_ptr;
                end else begin
                    // Nothing to replace: acts as a plain push, but the pop
                    // half still found the stack empty
                    w_wr_en   = 1'b1;
                    w_wp_nxt  = w_inc_ptr;
                    w_cnt_nxt = C_ONE_CNT;
                    w_unf_set = 1'b1;
                end
            end
            2'b10: begin
                if (!w_full) begin
                    w_wr_en   = 1'b1;
                    w_wp_nxt  = w_inc_ptr;
                    w_cnt_nxt = r_count + C_ONE_CNT;
                end else begin
                    w_ovf_set = 1'b1;
                    if (OVF_MODE == 0) begin
                        // Wrap policy: oldest slot is the one overwritten
                        w_wr_en  = 1'b1;
                        w_wp_nxt = w_inc_ptr;
                    end
                end
            end
            2'b01: begin
                if (!w_empty) begin
                    w_wp_nxt  = w_top_ptr;
                    w_cnt_nxt = r_count - C_ONE_CNT;
                end else begin
                    w_unf_set = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Pointer, occupancy and sticky flags; a new event beats clr_flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_wp    <= w_wp_nxt;
            r_count <= w_cnt_nxt;
            r_ovf   <= w_ovf_set | (r_ovf & ~clr_flags);
            r_unf   <= w_unf_set | (r_unf & ~clr_flags);
        end
    end

    // Entry storage is never cleared; writes are discarded while in reset
    always_ff @(posedge clk) begin
        if (!reset && w_wr_en) begin
            r_mem[w_wr_ptr] <= push_data;
        end
    end

    assign top_data  = w_empty ? '0 : r_mem[w_top_ptr];
    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_ovf;
    assign underflow = r_unf;

`ifdef CALL_STACK_DBG_EN
    localparam logic [PTR_W:0] C_DEPTH_EXT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] w_dbg_ptr;
    logic [PTR_W:0]   w_dbg_wrap;

    assign w_dbg_wrap = ({1'b0, w_top_ptr} + C_DEPTH_EXT) - {1'b0, dbg_idx};

    // Walk dbg_idx slots below top, wrapping back through the circular array
    always_comb begin
        w_dbg_ptr = w_top_ptr - dbg_idx;
        if (dbg_idx > w_top_ptr) begin
            w_dbg_ptr = w_dbg_wrap[PTR_W-1:0];
        end
    end

    assign dbg_data = (CNT_W'(dbg_idx) < r_count) ? r_mem[w_dbg_ptr] : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_call_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_call_stack_ctrl
// Brief    : Self-checking bench for call_stack_ctrl. Three instances share one
//            stimulus stream: DEPTH=4 wrap, DEPTH=4 reject, DEPTH=5 wrap. Each
//            has a list-based reference model (index 0 = oldest entry).
// Revision : 1.0 - initial release
// ============================================================================
module tb_call_stack_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        push;
    logic        pop;
    logic [10:0] push_data;
    logic        clr_flags;

    logic [10:0] top_a, top_b, top_c;
    logic [2:0]  cnt_a, cnt_b, cnt_c;
    logic        emp_a, emp_b, emp_c;
    logic        ful_a, ful_b, ful_c;
    logic        ovf_a, ovf_b, ovf_c;
    logic        unf_a, unf_b, unf_c;

`ifdef CALL_STACK_DBG_EN
    logic [1:0]  dbg_idx_a;
    logic [2:0]  dbg_idx_c;
    logic [1:0]  dbg_idx_b;
    logic [10:0] dbg_a, dbg_b, dbg_c;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    call_stack_ctrl #(.ADDR_W(11), .DEPTH(4), .OVF_MODE(0)) u_a (
        .clk(clk), .reset(reset), .push(push), .pop(pop),
        .push_data(push_data), .clr_flags(clr_flags),
`ifdef CALL_STACK_DBG_EN
        .dbg_idx(dbg_idx_a), .dbg_data(dbg_a),
`endif
        .top_data(top_a), .count(cnt_a), .empty(emp_a), .full(ful_a),
        .overflow(ovf_a), .underflow(unf_a)
    );

    call_stack_ctrl #(.ADDR_W(11), .DEPTH(4), .OVF_MODE(1)) u_b (
        .clk(clk), .reset(reset), .push(push), .pop(pop),
        .push_data(push_data), .clr_flags(clr_flags),
`ifdef CALL_STACK_DBG_EN
        .dbg_idx(dbg_idx_b), .dbg_data(dbg_b),
`endif
        .top_data(top_b), .count(cnt_b), .empty(emp_b), .full(ful_b),
        .overflow(ovf_b), .underflow(unf_b)
    );

    call_stack_ctrl #(.ADDR_W(11), .DEPTH(5), .OVF_MODE(0)) u_c (
        .clk(clk), .reset(reset), .push(push), .pop(pop),
        .push_data(push_data), .clr_flags(clr_flags),
`ifdef CALL_STACK_DBG_EN
        .dbg_idx(dbg_idx_c), .dbg_data(dbg_c),
`endif
        .top_data(top_c), .count(cnt_c), .empty(emp_c), .full(ful_c),
        .overflow(ovf_c), .underflow(unf_c)
    );

    // Reference model: list of entries, index 0 oldest, size-1 is top
    int mdepth [3];
    int mmode  [3];
    int msize  [3];
    int mstk   [3][8];
    bit movf   [3];
    bit munf   [3];

    function automatic int mtop(int k);
        return (msize[k] > 0) ? mstk[k][msize[k]-1] : 0;
    endfunction

    function automatic int mdbg(int k, int idx);
        return (idx < msize[k]) ? mstk[k][msize[k]-1-idx] : 0;
    endfunction

    task automatic model_step(int k, bit pu, bit po, int d, bit clr, bit rst);
        bit so = 1'b0;
        bit su = 1'b0;
        int n  = msize[k];
        if (rst) begin
            msize[k] = 0;
            movf[k]  = 1'b0;
            munf[k]  = 1'b0;
            return;
        end
        if (pu && po) begin
            if (n > 0) mstk[k][n-1] = d;
            else begin
                mstk[k][0] = d;
                msize[k]   = 1;
                su         = 1'b1;
            end
        end else if (pu) begin
            if (n < mdepth[k]) begin
                mstk[k][n] = d;
                msize[k]   = n + 1;
            end else begin
                so = 1'b1;
                if (mmode[k] == 0) begin
                    for (int i = 0; i < n - 1; i++) mstk[k][i] = mstk[k][i+1];
                    mstk[k][n-1] = d;
                end
            end
        end else if (po) begin
            if (n > 0) msize[k] = n - 1;
            else su = 1'b1;
        end
        movf[k] = so | (movf[k] & ~clr);
        munf[k] = su | (munf[k] & ~clr);
    endtask

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    logic [10:0] d_top [3];
    logic [3:0]  d_cnt [3];
    logic        d_emp [3];
    logic        d_ful [3];
    logic        d_ovf [3];
    logic        d_unf [3];

    assign d_top[0] = top_a;  assign d_top[1] = top_b;  assign d_top[2] = top_c;
    assign d_cnt[0] = {1'b0, cnt_a};
    assign d_cnt[1] = {1'b0, cnt_b};
    assign d_cnt[2] = {1'b0, cnt_c};
    assign d_emp[0] = emp_a;  assign d_emp[1] = emp_b;  assign d_emp[2] = emp_c;
    assign d_ful[0] = ful_a;  assign d_ful[1] = ful_b;  assign d_ful[2] = ful_c;
    assign d_ovf[0] = ovf_a;  assign d_ovf[1] = ovf_b;  assign d_ovf[2] = ovf_c;
    assign d_unf[0] = unf_a;  assign d_unf[1] = unf_b;  assign d_unf[2] = unf_c;

    // Every cycle, compare all instances against the model on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("top[%0d]", k),   d_top[k], mtop(k));
                chk($sformatf("count[%0d]", k), d_cnt[k], msize[k]);
                chk($sformatf("empty[%0d]", k), d_emp[k], (msize[k] == 0) ? 1 : 0);
                chk($sformatf("full[%0d]", k),  d_ful[k], (msize[k] == mdepth[k]) ? 1 : 0);
                chk($sformatf("ovf[%0d]", k),   d_ovf[k], movf[k]);
                chk($sformatf("unf[%0d]", k),   d_unf[k], munf[k]);
            end
`ifdef CALL_STACK_DBG_EN
            chk("dbg[0]", dbg_a, mdbg(0, dbg_idx_a));
            chk("dbg[1]", dbg_b, mdbg(1, dbg_idx_b));
            chk("dbg[2]", dbg_c, mdbg(2, dbg_idx_c));
`endif
        end
    end

    // One clock of stimulus; the model advances with the same inputs
    task automatic cyc(bit pu, bit po, int d, bit clr, bit rst);
        push      = pu;
        pop       = po;
        push_data = 11'(d);
        clr_flags = clr;
        reset     = rst;
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k, pu, po, d, clr, rst);
        #1;
    endtask

    int exp_a [4];
    int exp_b [4];

    initial begin
        mdepth[0] = 4; mmode[0] = 0;
        mdepth[1] = 4; mmode[1] = 1;
        mdepth[2] = 5; mmode[2] = 0;
        for (int k = 0; k < 3; k++) begin
            msize[k] = 0; movf[k] = 1'b0; munf[k] = 1'b0;
        end
`ifdef CALL_STACK_DBG_EN
        dbg_idx_a = '0; dbg_idx_b = '0; dbg_idx_c = '0;
`endif
        cyc(0, 0, 0, 0, 1);
        chk_en = 1'b1;
        cyc(0, 0, 0, 0, 1);
        chk("rst_count", cnt_a, 0);
        chk("rst_empty", emp_a, 1);
        chk("rst_top", top_a, 0);

        // Basic push/pop
        cyc(1, 0, 'h010, 0, 0);
        cyc(1, 0, 'h020, 0, 0);
        cyc(1, 0, 'h030, 0, 0);
        chk("p3_count", cnt_a, 3);
        chk("p3_top", top_a, 'h030);
        chk("p3_full", ful_a, 0);
        cyc(0, 1, 0, 0, 0);  chk("pop1_top", top_a, 'h020);
        cyc(0, 1, 0, 0, 0);  chk("pop2_top", top_a, 'h010);
        cyc(0, 1, 0, 0, 0);  chk("pop3_top", top_a, 0);
        chk("pop3_empty", emp_a, 1);
        chk("pop3_unf", unf_a, 0);

        // Overflow policies
        cyc(0, 0, 0, 0, 1);
        for (int i = 1; i <= 5; i++) cyc(1, 0, i, 0, 0);
        chk("ovfA_full", ful_a, 1);
        chk("ovfA_count", cnt_a, 4);
        chk("ovfA_flag", ovf_a, 1);
        chk("ovfA_top", top_a, 5);
        chk("ovfB_flag", ovf_b, 1);
        chk("ovfB_top", top_b, 4);
        chk("ovfC_top", top_c, 5);
        chk("ovfC_flag", ovf_c, 0);
        exp_a = '{4, 3, 2, 0};
        exp_b = '{3, 2, 1, 0};
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 0, 0);
            chk($sformatf("wrap_pop%0d", i), top_a, exp_a[i]);
            chk($sformatf("rej_pop%0d", i), top_b, exp_b[i]);
        end

        // Underflow and clear priority
        cyc(0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0);
        chk("unf_set", unf_a, 1);
        chk("unf_count", cnt_a, 0);
        chk("unf_top", top_a, 0);
        cyc(0, 1, 0, 1, 0);
        chk("unf_setwins", unf_a, 1);
        cyc(0, 0, 0, 1, 0);
        chk("unf_clr", unf_a, 0);

        // Tail-call replace
        cyc(0, 0, 0, 0, 1);
        cyc(1, 0, 'h100, 0, 0);
        cyc(1, 0, 'h200, 0, 0);
        cyc(1, 1, 'h2AA, 0, 0);
        chk("rep_count", cnt_a, 2);
        chk("rep_top", top_a, 'h2AA);
        cyc(0, 1, 0, 0, 0);
        chk("rep_pop_top", top_a, 'h100);
        cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 'h055, 0, 0);
        chk("repE_count", cnt_a, 1);
        chk("repE_top", top_a, 'h055);
        chk("repE_unf", unf_a, 1);

        // Reset beats an in-flight push
        cyc(1, 0, 'h7FF, 0, 0);
        cyc(1, 0, 'h7FF, 0, 0);
        cyc(1, 0, 'h7FF, 0, 0);
        cyc(1, 0, 'h7FF, 0, 1);
        chk("rstp_count", cnt_a, 0);
        chk("rstp_empty", emp_a, 1);
        chk("rstp_ovf", ovf_a, 0);
        chk("rstp_unf", unf_a, 0);
        chk("rstp_top", top_a, 0);

`ifdef CALL_STACK_DBG_EN
        cyc(1, 0, 'h00A, 0, 0);
        cyc(1, 0, 'h00B, 0, 0);
        dbg_idx_a = 2'd1;
        #1 chk("dbg_idx1", dbg_a, 'h00A);
        dbg_idx_a = 2'd2;
        #1 chk("dbg_idx2", dbg_a, 0);
`endif

        // Randomised traffic with alternating fill/drain bias
        for (int i = 0; i < 3000; i++) begin
            int r_pu;
            int r_po;
            bit pu;
            bit po;
            r_pu = ((i / 150) % 2 == 0) ? 65 : 30;
            r_po = ((i / 150) % 2 == 0) ? 30 : 65;
            pu = ($urandom_range(0, 99) < r_pu);
            po = ($urandom_range(0, 99) < r_po);
`ifdef CALL_STACK_DBG_EN
            dbg_idx_a = 2'($urandom_range(0, 3));
            dbg_idx_b = 2'($urandom_range(0, 3));
            dbg_idx_c = 3'($urandom_range(0, 7));
`endif
            cyc(pu, po, int'($urandom_range(0, 2047)),
                ($urandom_range(0, 99) < 6), ($urandom_range(0, 199) == 0));
        end

        cyc(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/call_stack_ctrl.md
Name: call_stack_ctrl

Overview:
Parametrised hardware return-address stack for the MCU core. It holds CALL return addresses and supplies the RETURN target to the PC-select mux. It generalises the fixed stack with configurable depth and width, occupancy/full/empty status, sticky overflow/underflow flags, a selectable overflow policy, and defined simultaneous push+pop (tail-call replace).

Parameters:
ADDR_W, 11, width of a stored return address (PC width)
DEPTH, 16, number of entries; any value >= 2 (not restricted to powers of two)
OVF_MODE, 0, push-when-full policy: 0 = wrap (overwrite oldest), 1 = reject (push dropped)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
push  in  1  store push_data as new top this cycle
pop  in  1  remove top entry this cycle
push_data  in  ADDR_W  return address to store
clr_flags  in  1  clear sticky overflow/underflow
top_data  out  ADDR_W  current top entry (combinational from state); 0 when empty
count  out  $clog2(DEPTH+1)  number of valid entries, 0..DEPTH
empty  out  1  count == 0
full  out  1  count == DEPTH
overflow  out  1  sticky: a push occurred while full
underflow  out  1  sticky: a pop occurred while empty

Behaviour:
- Reset: write pointer 0, count 0, overflow 0, underflow 0. Storage array not cleared. top_data = 0 and empty = 1 the cycle after reset.
- Storage is a circular array. wp is the next write slot. Top slot = wp-1, wrapped explicitly modulo DEPTH (DEPTH-1 when wp = 0).
- top_data is combinational from registers. It is valid in the same cycle pop is asserted, so the PC mux loads it on that edge. Push/pop effects appear on top_data/count in the cycle after the edge.
- push only, not full: mem[wp] <= push_data; wp <= wp+1 (wrap at DEPTH to 0); count+1.
- push only, full, OVF_MODE=0: write and advance wp as normal, count stays DEPTH, oldest entry lost, overflow <= 1.
- push only, full, OVF_MODE=1: no write, wp/count unchanged, overflow <= 1.
- pop only, not empty: wp <= wp-1 (wrap), count-1. The entry is not erased.
- pop only, empty: no state change except underflow <= 1. top_data stays 0.
- push and pop, count > 0: replace top, i.e. mem[wp-1] <= push_data; wp and count unchanged; no flag change (full stays full).
- push and pop, empty: behaves as push (count becomes 1) and underflow <= 1.
- clr_flags: overflow and underflow <= 0. If a new overflow/underflow event occurs in the same cycle, the set wins for that flag.
- reset has priority over all inputs, including mid-sequence push/pop. Any in-flight operation is discarded.
- Arithmetic: pointers are $clog2(DEPTH) bits, compared explicitly against DEPTH-1 for wrap. count never exceeds DEPTH and never goes below 0.

Optional Feature:
Macro CALL_STACK_DBG_EN.
- Defined: adds port dbg_idx (in, $clog2(DEPTH)) and port dbg_data (out, ADDR_W). dbg_data is combinational: the entry dbg_idx positions below top (0 = top). It reads 0 when dbg_idx >= count. It is read-only and never affects stack state.
- Undefined: the ports are absent, with no debug read mux logic.

Test Plan:
- DEPTH=4, reset, then push 0x010, 0x020, 0x030 on consecutive cycles -> count=3, top_data=0x030, empty=0, full=0. Then pop ×3 -> top_data steps 0x020, 0x010, 0 and empty=1, underflow=0.
- DEPTH=4, OVF_MODE=0: push 0x1,0x2,0x3,0x4,0x5 -> full=1, count=4, overflow=1, top=0x5. Pop ×4 -> tops 0x4, 0x3, 0x2, then empty (0x1 lost).
- DEPTH=4, OVF_MODE=1: same 5 pushes -> overflow=1, top=0x4. Pops return 0x4, 0x3, 0x2, 0x1.
- Empty stack, pop -> underflow=1, count=0, top=0. Next cycle assert clr_flags and pop together -> underflow stays 1 (set wins). Then clr_flags alone -> underflow=0.
- Push 0x100, 0x200, then push+pop with push_data=0x2AA -> count=2, top=0x2AA. Pop -> top=0x100. Push+pop on empty with 0x055 -> count=1, top=0x055, underflow=1.
- Push 0x7FF ×3, assert reset for one cycle with push=1 -> count=0, empty=1, flags 0, top=0. With CALL_STACK_DBG_EN, after pushing 0xA, 0xB: dbg_idx=1 -> dbg_data=0xA; dbg_idx=2 -> 0.
